fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Instruction queue between the Fetch stage and the Decode stage.
- Each entry holds {PC, instruction, branch prediction} as captured from Fetch.
- Entries are presented first-word-fall-through to Decode under a valid/ready handshake.
- Back-pressures Fetch through a registered freeze. Flushes all contents on branch redirect or mispredict.

Parameters:
- INSTR_WIDTH, 27, instruction word width.
- ADDR_WIDTH, 7, PC width.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_Fetch_Valid  input  1  Fetch is presenting a new instruction this cycle.
- i_Pc  input  ADDR_WIDTH  PC from Fetch.
- i_Instruction  input  INSTR_WIDTH  instruction word from Fetch.
- i_Prediction  input  1  branch prediction bit from Fetch.
- i_Flush  input  1  discard all entries (branch taken or mispredict).
- i_Decode_Ready  input  1  Decode accepts the head entry this cycle.
- o_Valid  output  1  head entry is valid.
- o_Pc  output  ADDR_WIDTH  head PC.
- o_Instruction  output  INSTR_WIDTH  head instruction.
- o_Prediction  output  1  head prediction bit.
- o_Freeze  output  1  registered back-pressure to Fetch (drives Fetch i_Freeze).
- o_Count  output  $clog2(DEPTH+1)  current occupancy.
- o_Overflow  output  1  sticky error flag: a push was dropped.

Behaviour:
- Storage and pointers:
  - Circular buffer; write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - The occupancy counter is kept separately and is the single source of full/empty.
- Reset (synchronous): pointers = 0, count = 0, o_Freeze = 0, o_Overflow = 0, o_Valid = 0. Storage contents are don't-care.
- Head output:
  - o_Valid = (count != 0), combinational from registered count.
  - o_Pc, o_Instruction and o_Prediction come from the entry at the read pointer.
  - When o_Valid = 0 these outputs are don't-care; the bench must not check them.
- Pop: pop = o_Valid && i_Decode_Ready. Advances the read pointer at the clock edge.
- Push:
  - push = i_Fetch_Valid && (count < DEPTH || pop).
  - Writes {i_Pc, i_Instruction, i_Prediction} at the write pointer and advances it.
- Drop:
  - If i_Fetch_Valid && count == DEPTH && !pop, the data is dropped and o_Overflow sets.
  - o_Overflow stays set until reset; it is not cleared by flush.
- Count update:
  - +1 on push only, -1 on pop only, unchanged when push and pop occur together.
  - Simultaneous push and pop when empty is impossible, since pop requires o_Valid.
- Latency: an entry pushed at edge N is visible on the outputs (o_Valid = 1) after edge N. Latency is one cycle, with no bypass path from input to output.
- Freeze:
  - At each edge, o_Freeze <= (next_count >= DEPTH-1).
  - This leaves one slot of slack for the instruction Fetch issues in the cycle it sees freeze.
  - It deasserts at the edge where next_count drops below DEPTH-1.
- Flush (priority over push and pop):
  - If i_Flush = 1, then at the edge: pointers = 0, count = 0, o_Freeze = 0.
  - Any same-cycle push is discarded and the same-cycle pop is ignored; Decode must treat that cycle's head as squashed.
  - o_Valid = 0 from the next cycle.
- Reset has priority over flush. Reset mid-operation discards all entries within one cycle.
- No combinational path from i_Decode_Ready or i_Fetch_Valid to o_Freeze.

Test Plan:
- Reset, then 3 pushes with PC = 0, 1, 2 and i_Decode_Ready = 0 -> o_Count = 3, o_Freeze = 1 after the third edge, o_Valid = 1, o_Pc = 0.
- Continue with a fourth push (PC = 3), then a fifth push attempt (PC = 4) with ready low -> fourth accepted and o_Count = 4; fifth dropped and o_Overflow = 1; o_Pc remains 0.
- Full queue, raise i_Decode_Ready for 4 cycles with no pushes -> o_Pc sequence 0, 1, 2, 3; then o_Valid = 0, o_Count = 0. o_Freeze clears at the edge where count falls to 2.
- Steady stream with ready held high, PC 10..17 pushed every cycle -> each PC appears exactly one cycle after its push, o_Count holds at 1, o_Freeze stays 0. Pointer wraps past DEPTH are seamless.
- With 2 entries (PC = 20 and 21, i_Prediction = 1), assert i_Flush together with a push of PC = 22 -> next cycle o_Valid = 0 and o_Count = 0. A following push of PC = 30 appears as head with o_Prediction = i_Prediction.
- Assert reset while 3 entries are held and o_Freeze = 1 -> after the edge, o_Count = 0, o_Valid = 0, o_Freeze = 0, o_Overflow = 0.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer presented
// first-word-fall-through, with registered freeze back-pressure.
module fetch_decode_queue #(
    parameter int INSTR_WIDTH = 27,
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_Fetch_Valid,
    input  logic [ADDR_WIDTH-1:0]        i_Pc,
    input  logic [INSTR_WIDTH-1:0]       i_Instruction,
    input  logic                         i_Prediction,
    input  logic                         i_Flush,
    input  logic                         i_Decode_Ready,
    output logic                         o_Valid,
    output logic [ADDR_WIDTH-1:0]        o_Pc,
    output logic [INSTR_WIDTH-1:0]       o_Instruction,
    output logic                         o_Prediction,
    output logic                         o_Freeze,
    output logic [$clog2(DEPTH+1)-1:0]   o_Count,
    output logic                         o_Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH-1);

    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]       pred_mem;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          push;
    logic          pop;
    logic          drop;

    assign o_Valid       = (count != '0);
    assign o_Pc          = pc_mem[rd_ptr];
    assign o_Instruction = instr_mem[rd_ptr];
    assign o_Prediction  = pred_mem[rd_ptr];
    assign o_Count       = count;

    always_comb begin
        pop        = o_Valid && i_Decode_Ready;
        push       = i_Fetch_Valid && ((count < FULL) || pop);
        drop       = i_Fetch_Valid && (count == FULL) && !pop;
        next_count = count;
        if (push && !pop)
            next_count = count + CW'(1);
        else if (pop && !push)
            next_count = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Freeze   <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            if (drop)
                o_Overflow <= 1'b1;
            if (i_Flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                o_Freeze <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= next_count;
                // one slot of slack for the fetch issued while freeze is seen
                o_Freeze <= (next_count >= ALMOST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !i_Flush) begin
            pc_mem[wr_ptr]    <= i_Pc;
            instr_mem[wr_ptr] <= i_Instruction;
            pred_mem[wr_ptr]  <= i_Prediction;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed plan steps plus random
// traffic checked against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int IW = 27;
    localparam int AW = 7;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          i_Fetch_Valid;
    logic [AW-1:0] i_Pc;
    logic [IW-1:0] i_Instruction;
    logic          i_Prediction;
    logic          i_Flush;
    logic          i_Decode_Ready;
    logic          o_Valid;
    logic [AW-1:0] o_Pc;
    logic [IW-1:0] o_Instruction;
    logic          o_Prediction;
    logic          o_Freeze;
    logic [CW-1:0] o_Count;
    logic          o_Overflow;

    fetch_decode_queue #(
        .INSTR_WIDTH(IW),
        .ADDR_WIDTH(AW),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_Fetch_Valid(i_Fetch_Valid),
        .i_Pc(i_Pc),
        .i_Instruction(i_Instruction),
        .i_Prediction(i_Prediction),
        .i_Flush(i_Flush),
        .i_Decode_Ready(i_Decode_Ready),
        .o_Valid(o_Valid),
        .o_Pc(o_Pc),
        .o_Instruction(o_Instruction),
        .o_Prediction(o_Prediction),
        .o_Freeze(o_Freeze),
        .o_Count(o_Count),
        .o_Overflow(o_Overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic          pred;
    } entry_t;

    entry_t m_q[$];
    bit     m_ovf;
    bit     m_frz;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit drop;
        entry_t e;
        if (reset) begin
            m_q.delete();
            m_ovf = 0;
            m_frz = 0;
            return;
        end
        pop  = (m_q.size() != 0) && i_Decode_Ready;
        drop = i_Fetch_Valid && (m_q.size() == D) && !pop;
        if (drop) m_ovf = 1;
        if (i_Flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (i_Fetch_Valid && !drop) begin
                e.pc    = i_Pc;
                e.instr = i_Instruction;
                e.pred  = i_Prediction;
                m_q.push_back(e);
            end
        end
        m_frz = (m_q.size() >= D - 1);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(o_Valid), 32'(m_q.size() != 0));
        chk({tag, ".count"}, 32'(o_Count), 32'(m_q.size()));
        chk({tag, ".freeze"}, 32'(o_Freeze), 32'(m_frz));
        chk({tag, ".ovf"}, 32'(o_Overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk({tag, ".pc"}, 32'(o_Pc), 32'(m_q[0].pc));
            chk({tag, ".instr"}, 32'(o_Instruction),
                32'(m_q[0].instr));
            chk({tag, ".pred"}, 32'(o_Prediction), 32'(m_q[0].pred));
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit fv, input int pc, input bit pred,
                         input bit rdy, input bit fl);
        i_Fetch_Valid  = fv;
        i_Pc           = AW'(pc);
        i_Instruction  = IW'($urandom);
        i_Prediction   = pred;
        i_Decode_Ready = rdy;
        i_Flush        = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle("rst");
        cycle("rst2");
        chk("rst.count", 32'(o_Count), 0);
        chk("rst.valid", 32'(o_Valid), 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(1, i, 0, 0, 0);
            cycle("fill");
        end
        chk("t1.count", 32'(o_Count), 3);
        chk("t1.freeze", 32'(o_Freeze), 1);
        chk("t1.valid", 32'(o_Valid), 1);
        chk("t1.pc", 32'(o_Pc), 0);

        drive(1, 3, 0, 0, 0);
        cycle("push4");
        chk("t2.count", 32'(o_Count), 4);
        drive(1, 4, 0, 0, 0);
        cycle("push5");
        chk("t2.ovf", 32'(o_Overflow), 1);
        chk("t2.count5", 32'(o_Count), 4);
        chk("t2.pc", 32'(o_Pc), 0);

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("t3.head", 32'(o_Pc), 32'(i));
            cycle("drain");
            if (i == 0) chk("t3.frz3", 32'(o_Freeze), 1);
            if (i == 1) chk("t3.frz2", 32'(o_Freeze), 0);
        end
        chk("t3.valid", 32'(o_Valid), 0);
        chk("t3.count", 32'(o_Count), 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 10 + i, 0, 1, 0);
            cycle("stream");
            chk("t4.pc", 32'(o_Pc), 32'(10 + i));
            chk("t4.count", 32'(o_Count), 1);
            chk("t4.freeze", 32'(o_Freeze), 0);
        end
        drive(0, 0, 0, 1, 0);
        cycle("empty");

        drive(1, 20, 1, 0, 0);
        cycle("p20");
        drive(1, 21, 1, 0, 0);
        cycle("p21");
        drive(1, 22, 1, 0, 1);
        cycle("flush");
        chk("t5.valid", 32'(o_Valid), 0);
        chk("t5.count", 32'(o_Count), 0);
        drive(1, 30, 1, 0, 0);
        cycle("p30");
        chk("t5.pc", 32'(o_Pc), 30);
        chk("t5.pred", 32'(o_Prediction), 1);

        drive(1, 31, 0, 0, 0);
        cycle("p31");
        drive(1, 32, 0, 0, 0);
        cycle("p32");
        chk("t6.frz", 32'(o_Freeze), 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle("rst_mid");
        reset = 1'b0;
        chk("t6.count", 32'(o_Count), 0);
        chk("t6.valid", 32'(o_Valid), 0);
        chk("t6.freeze", 32'(o_Freeze), 0);
        chk("t6.ovf", 32'(o_Overflow), 0);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom),
                  1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 150) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
